// File: rtl/e203_ifu_litebpu_fsm_pkg.sv
// Shared widths, target-adder operand selection and small helpers for the lite BPU.
package e203_ifu_litebpu_fsm_pkg;

    localparam int PC_W    = 32;
    localparam int XLEN    = 32;
    localparam int RFIDX_W = 5;

    typedef enum logic [1:0] {
        OP1_PC   = 2'd0,
        OP1_ZERO = 2'd1,
        OP1_X1   = 2'd2,
        OP1_RS1  = 2'd3
    } op1_sel_t;

    function automatic logic [PC_W-1:0] seq_inc(input logic rv32);
        seq_inc = rv32 ? PC_W'(4) : PC_W'(2);
    endfunction

endpackage

// File: rtl/e203_ifu_litebpu_fsm_if.sv
// Mini-decoder to BPU request bundle plus the prediction returned to ifetch.
interface e203_ifu_litebpu_fsm_if;
    import e203_ifu_litebpu_fsm_pkg::*;

    logic               dec_i_valid;
    logic [PC_W-1:0]    pc;
    logic               dec_rv32;
    logic               dec_jal;
    logic               dec_jalr;
    logic               dec_bxx;
    logic [RFIDX_W-1:0] dec_jalr_rs1idx;
    logic [XLEN-1:0]    dec_bjp_imm;

    logic               bpu_wait;
    logic               bpu_o_valid;
    logic               prdt_taken;
    logic [PC_W-1:0]    prdt_pc;

    modport master (
        output dec_i_valid, pc, dec_rv32, dec_jal, dec_jalr, dec_bxx,
               dec_jalr_rs1idx, dec_bjp_imm,
        input  bpu_wait, bpu_o_valid, prdt_taken, prdt_pc
    );

    modport slave (
        input  dec_i_valid, pc, dec_rv32, dec_jal, dec_jalr, dec_bxx,
               dec_jalr_rs1idx, dec_bjp_imm,
        output bpu_wait, bpu_o_valid, prdt_taken, prdt_pc
    );

endinterface

// File: rtl/e203_ifu_bpu_tgtadd.sv
// Branch target adder (op1 + imm) and sequential fall-through adder, both modulo 2^PC_W.
// Purely combinational; no backpressure.
module e203_ifu_bpu_tgtadd
    import e203_ifu_litebpu_fsm_pkg::*;
(
    input  op1_sel_t        op1_sel,
    input  logic [PC_W-1:0] pc,
    input  logic [XLEN-1:0] x1,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    input  logic            rv32,
    output logic [PC_W-1:0] tgt,
    output logic [PC_W-1:0] seq
);

    logic [PC_W-1:0] op1;

    always_comb begin
        op1 = '0;
        unique case (op1_sel)
            OP1_PC:   op1 = pc;
            OP1_ZERO: op1 = '0;
            OP1_X1:   op1 = x1[PC_W-1:0];
            OP1_RS1:  op1 = rs1[PC_W-1:0];
            default:  op1 = '0;
        endcase
    end

    assign tgt = op1 + imm[PC_W-1:0];
    assign seq = pc + seq_inc(rv32);

endmodule

// File: rtl/e203_ifu_litebpu_fsm.sv
// Static predictor / next-PC generator; BXX/JAL/JALR-x0 resolve in 0 cycles, JALR x1 waits on hazards,
// JALR xn waits on hazards then spends 1 cycle reading rs1; bpu_wait holds fetch, flush/rst win over all.
module e203_ifu_litebpu_fsm
    import e203_ifu_litebpu_fsm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    e203_ifu_litebpu_fsm_if.slave bpu,
    input  logic               flush,
    input  logic               oitf_empty,
    input  logic               ir_valid,
    input  logic               ir_rdwen,
    input  logic [RFIDX_W-1:0] ir_rdidx,
    input  logic [XLEN-1:0]    rf2bpu_x1,
    input  logic [XLEN-1:0]    rf2bpu_rs1,
    output logic               bpu2rf_rs1_ena
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_DEP = 2'd1;
    localparam logic [1:0] RD_RF    = 2'd2;

    logic [1:0]      state;
    logic [1:0]      nxt_state;
    op1_sel_t        op1_sel;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] seq;
    logic            vld;
    logic            taken;
    logic            wait_c;
    logic            rs1_ena;

    logic jalr_x0;
    logic jalr_x1;
    logic jalr_xn;
    logic dep1;
    logic depn;

    assign jalr_x0 = bpu.dec_jalr & (bpu.dec_jalr_rs1idx == RFIDX_W'(0));
    assign jalr_x1 = bpu.dec_jalr & (bpu.dec_jalr_rs1idx == RFIDX_W'(1));
    assign jalr_xn = bpu.dec_jalr & (bpu.dec_jalr_rs1idx >  RFIDX_W'(1));

    // x1 only conflicts with an IR writer of x1; xn is conservative and stalls on any IR occupant.
    assign dep1 = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == RFIDX_W'(1)));
    assign depn = ~oitf_empty | ir_valid;

    always_comb begin
        nxt_state = state;
        vld       = 1'b0;
        taken     = 1'b0;
        wait_c    = 1'b0;
        rs1_ena   = 1'b0;
        op1_sel   = OP1_PC;
        if (rst || flush || !bpu.dec_i_valid) begin
            nxt_state = IDLE;
        end else if (state == RD_RF) begin
            // Read data arrives now; the dependency check already passed before the read.
            vld       = 1'b1;
            taken     = 1'b1;
            op1_sel   = OP1_RS1;
            nxt_state = IDLE;
        end else if (jalr_x1) begin
            if (dep1) begin
                wait_c    = 1'b1;
                nxt_state = WAIT_DEP;
            end else begin
                vld       = 1'b1;
                taken     = 1'b1;
                op1_sel   = OP1_X1;
                nxt_state = IDLE;
            end
        end else if (jalr_xn) begin
            wait_c = 1'b1;
            if (depn) begin
                nxt_state = WAIT_DEP;
            end else begin
                rs1_ena   = 1'b1;
                nxt_state = RD_RF;
            end
        end else begin
            vld       = 1'b1;
            nxt_state = IDLE;
            if (bpu.dec_jal) begin
                taken = 1'b1;
            end else if (bpu.dec_bxx) begin
                taken = bpu.dec_bjp_imm[XLEN-1];
            end else if (jalr_x0) begin
                taken   = 1'b1;
                op1_sel = OP1_ZERO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    e203_ifu_bpu_tgtadd u_tgtadd (
        .op1_sel (op1_sel),
        .pc      (bpu.pc),
        .x1      (rf2bpu_x1),
        .rs1     (rf2bpu_rs1),
        .imm     (bpu.dec_bjp_imm),
        .rv32    (bpu.dec_rv32),
        .tgt     (tgt),
        .seq     (seq)
    );

    assign bpu.bpu_o_valid = vld;
    assign bpu.bpu_wait    = wait_c;
    assign bpu.prdt_taken  = taken;
    assign bpu.prdt_pc     = vld ? (taken ? tgt : seq) : '0;
    assign bpu2rf_rs1_ena  = rs1_ena;

endmodule

// File: tb/tb_e203_ifu_litebpu_fsm.sv
module tb_e203_ifu_litebpu_fsm;
    import e203_ifu_litebpu_fsm_pkg::*;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               oitf_empty;
    logic               ir_valid;
    logic               ir_rdwen;
    logic [RFIDX_W-1:0] ir_rdidx;
    logic [XLEN-1:0]    rf2bpu_x1;
    logic [XLEN-1:0]    rf2bpu_rs1;
    logic               bpu2rf_rs1_ena;

    int errors = 0;
    int checks = 0;

    e203_ifu_litebpu_fsm_if bif();

    e203_ifu_litebpu_fsm dut (
        .clk            (clk),
        .rst            (rst),
        .bpu            (bif),
        .flush          (flush),
        .oitf_empty     (oitf_empty),
        .ir_valid       (ir_valid),
        .ir_rdwen       (ir_rdwen),
        .ir_rdidx       (ir_rdidx),
        .rf2bpu_x1      (rf2bpu_x1),
        .rf2bpu_rs1     (rf2bpu_rs1),
        .bpu2rf_rs1_ena (bpu2rf_rs1_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_wait, input logic e_ena,
                           input logic e_vld, input logic e_tkn, input logic [31:0] e_pc);
        chk({tag, ".wait"},  32'(bif.bpu_wait),    32'(e_wait));
        chk({tag, ".ena"},   32'(bpu2rf_rs1_ena),  32'(e_ena));
        chk({tag, ".valid"}, 32'(bif.bpu_o_valid), 32'(e_vld));
        chk({tag, ".taken"}, 32'(bif.prdt_taken),  32'(e_tkn));
        chk({tag, ".pc"},    bif.prdt_pc,          e_pc);
    endtask

    task automatic set_dec(input logic v, input logic [31:0] pcv, input logic rv32,
                           input logic jal, input logic jalr, input logic bxx,
                           input logic [4:0] idx, input logic [31:0] imm);
        bif.dec_i_valid     = v;
        bif.pc              = pcv;
        bif.dec_rv32        = rv32;
        bif.dec_jal         = jal;
        bif.dec_jalr        = jalr;
        bif.dec_bxx         = bxx;
        bif.dec_jalr_rs1idx = idx;
        bif.dec_bjp_imm     = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; oitf_empty = 1'b1;
        ir_valid = 1'b0; ir_rdwen = 1'b0; ir_rdidx = '0;
        rf2bpu_x1 = '0; rf2bpu_rs1 = '0;
        set_dec(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sample(); chk_out("reset", 0, 0, 0, 0, 32'h0);

        step(); rst = 1'b0;
        // T1: backward branch taken
        set_dec(1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFF0);
        sample(); chk_out("t1_bxx_back", 0, 0, 1, 1, 32'h70);

        // T2: forward branch not taken (16-bit), then JAL
        step(); set_dec(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h20);
        sample(); chk_out("t2_bxx_fwd", 0, 0, 1, 0, 32'h102);
        step(); set_dec(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h20);
        sample(); chk_out("t2_jal", 0, 0, 1, 1, 32'h120);

        step(); set_dec(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h400);
        sample(); chk_out("jalr_x0", 0, 0, 1, 1, 32'h400);

        // Output gating with dec_i_valid low
        step(); set_dec(1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h20);
        sample(); chk_out("gate_invalid", 0, 0, 0, 0, 32'h0);

        // T3: JALR x1 stalled 3 cycles by IR writer of x1
        step(); set_dec(1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'h4);
        rf2bpu_x1 = 32'h2000; ir_valid = 1'b1; ir_rdwen = 1'b1; ir_rdidx = 5'd1;
        for (int i = 0; i < 3; i++) begin
            sample(); chk_out($sformatf("t3_wait%0d", i), 1, 0, 0, 0, 32'h0);
            step();
        end
        ir_valid = 1'b0;
        sample(); chk_out("t3_resolve", 0, 0, 1, 1, 32'h2004);

        // JALR x1 with IR writing a different register: no stall
        step(); ir_valid = 1'b1; ir_rdidx = 5'd3; rf2bpu_x1 = 32'h1000;
        sample(); chk_out("x1_nodep", 0, 0, 1, 1, 32'h1004);

        // T4: JALR x5 without hazards
        step(); ir_valid = 1'b0; ir_rdwen = 1'b0;
        set_dec(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'hFFFF_FFF8);
        sample(); chk_out("t4_rd", 1, 1, 0, 0, 32'h0);
        step(); rf2bpu_rs1 = 32'h3000;
        sample(); chk_out("t4_resolve", 0, 0, 1, 1, 32'h2FF8);
        step(); set_dec(1'b0, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'hFFFF_FFF8);
        sample(); chk_out("t4_idle", 0, 0, 0, 0, 32'h0);

        // JALR xn through WAIT_DEP then RD_RF
        step(); set_dec(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h10);
        oitf_empty = 1'b0;
        sample(); chk_out("wd_wait", 1, 0, 0, 0, 32'h0);
        step(); oitf_empty = 1'b1;
        sample(); chk_out("wd_rd", 1, 1, 0, 0, 32'h0);
        step(); rf2bpu_rs1 = 32'h5000;
        sample(); chk_out("wd_resolve", 0, 0, 1, 1, 32'h5010);

        // T5: flush while in WAIT_DEP
        step(); set_dec(1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'h8);
        oitf_empty = 1'b0;
        sample(); chk_out("t5_wait", 1, 0, 0, 0, 32'h0);
        step(); flush = 1'b1;
        sample(); chk_out("t5_flush", 0, 0, 0, 0, 32'h0);
        step(); flush = 1'b0; bif.dec_i_valid = 1'b0; oitf_empty = 1'b1;
        sample(); chk_out("t5_after", 0, 0, 0, 0, 32'h0);

        // Flush discards a pending RD_RF: decoder re-presents and a fresh read starts
        step(); bif.dec_i_valid = 1'b1;
        sample(); chk_out("fl_rd", 1, 1, 0, 0, 32'h0);
        step(); flush = 1'b1;
        sample(); chk_out("fl_flush", 0, 0, 0, 0, 32'h0);
        step(); flush = 1'b0;
        sample(); chk_out("fl_restart", 1, 1, 0, 0, 32'h0);
        step(); rf2bpu_rs1 = 32'h100;
        sample(); chk_out("fl_resolve", 0, 0, 1, 1, 32'h108);

        // T6: wrap-around of the sequential PC
        step(); set_dec(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sample(); chk_out("t6_wrap", 0, 0, 1, 0, 32'h2);

        // T6: reset while in RD_RF
        step(); set_dec(1'b1, 32'h500, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h4);
        sample(); chk_out("rst_rd", 1, 1, 0, 0, 32'h0);
        step(); rst = 1'b1; rf2bpu_rs1 = 32'h7000;
        sample(); chk_out("rst_cycle", 0, 0, 0, 0, 32'h0);
        step(); rst = 1'b0; bif.dec_i_valid = 1'b0;
        sample(); chk_out("rst_after", 0, 0, 0, 0, 32'h0);
        step(); bif.dec_i_valid = 1'b1;
        sample(); chk_out("rst_idle", 1, 1, 0, 0, 32'h0);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
